// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC array and its output collection stage.
package mac_pkg;

    localparam int col           = 8;
    localparam int psum_bw       = 16;
    localparam int depth_default = 16;

    typedef logic [psum_bw-1:0] psum_t;
    typedef logic [psum_bw*col-1:0] psum_row_t;

endpackage

// File: rtl/mac_ofifo_if.sv
// Bus between the MAC array south edge / write-back path and the output FIFO.
// The slave side is the FIFO; the master side drives psums, strobes and reads.
interface mac_ofifo_if;
    import mac_pkg::*;

    psum_row_t      in;
    logic [col-1:0] wr;
    logic           rd;
    psum_row_t      out;
    logic           o_valid;
    logic           o_ready;
    logic           o_full;
    logic           o_overflow;

    modport slave (
        input  in,
        input  wr,
        input  rd,
        output out,
        output o_valid,
        output o_ready,
        output o_full,
        output o_overflow
    );

    modport master (
        output in,
        output wr,
        output rd,
        input  out,
        input  o_valid,
        input  o_ready,
        input  o_full,
        input  o_overflow
    );

endinterface

// File: rtl/ofifo_lane.sv
// Single-column synchronous FIFO. Head data is presented combinationally so the
// top level can register a whole row in the same cycle it pops every lane.
module ofifo_lane
    import mac_pkg::*;
#(
    parameter int depth = depth_default
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr,
    input  logic                   i_pop,
    input  psum_t                  i_din,
    output psum_t                  o_dout,
    output logic [$clog2(depth):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int ptr_bw = $clog2(depth);
    localparam logic [ptr_bw-1:0] PTR_ONE  = ptr_bw'(1);
    localparam logic [ptr_bw:0]   CNT_ONE  = (ptr_bw + 1)'(1);
    localparam logic [ptr_bw:0]   CNT_FULL = (ptr_bw + 1)'(depth);

    psum_t             r_mem [depth];
    logic [ptr_bw-1:0] r_wptr;
    logic [ptr_bw-1:0] r_rptr;
    logic [ptr_bw:0]   r_cnt;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_accept;

    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == CNT_FULL);
    // Popping an empty lane is masked so a stray pop can never corrupt pointers.
    assign w_pop    = i_pop & ~w_empty;
    // A full lane still takes a write when its head leaves in the same cycle.
    assign w_accept = i_wr & (~w_full | w_pop);

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at depth (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_cnt;
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/mac_ofifo.sv
// Output collection stage below the MAC array. Each column's skewed south-edge
// psum is queued in its own lane; a row is released only once every lane has
// data, so reads always return a column-aligned row.
module mac_ofifo
    import mac_pkg::*;
#(
    parameter int depth = depth_default
) (
    input  logic        clk,
    input  logic        reset,
    mac_ofifo_if.slave  bus
);

    localparam int ptr_bw = $clog2(depth);
    localparam logic [ptr_bw:0] CNT_FULL = (ptr_bw + 1)'(depth);

    psum_t           w_dout  [col];
    logic [ptr_bw:0] w_count [col];
    logic [col-1:0]  w_empty;
    logic [col-1:0]  w_lane_full;
    psum_row_t       w_row;
    logic            w_pop;
    logic            w_ready;
    logic            w_any_full;
    logic [col-1:0]  w_drop;

    psum_row_t r_out;
    logic      r_valid;
    logic      r_overflow;

    genvar g;
    generate
        for (g = 0; g < col; g++) begin : g_lane
            ofifo_lane #(
                .depth (depth)
            ) u_lane (
                .clk     (clk),
                .rst_n   (reset),
                .i_wr    (bus.wr[g]),
                .i_pop   (w_pop),
                .i_din   (bus.in[g*psum_bw +: psum_bw]),
                .o_dout  (w_dout[g]),
                .o_count (w_count[g]),
                .o_empty (w_empty[g]),
                .o_full  (w_lane_full[g])
            );
            assign w_row[g*psum_bw +: psum_bw] = w_dout[g];
        end
    endgenerate

    // Row availability and full status, both from pre-write registered counts so
    // a write landing this cycle can never be popped in the same cycle.
    always_comb begin
        w_ready    = 1'b1;
        w_any_full = 1'b0;
        for (int c = 0; c < col; c++) begin
            w_ready    = w_ready & (w_count[c] != '0);
            w_any_full = w_any_full | (w_count[c] == CNT_FULL);
        end
    end

    assign w_pop  = bus.rd & ~(|w_empty);
    assign w_drop = bus.wr & w_lane_full & {col{~w_pop}};

    // Output row register: captures the head row on every pop, otherwise holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_out <= w_row;
            end
        end
    end

    // Sticky overflow: any column write that found its lane full with no pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (|w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.out        = r_out;
    assign bus.o_valid    = r_valid;
    assign bus.o_ready    = w_ready;
    assign bus.o_full     = w_any_full;
    assign bus.o_overflow = r_overflow;

endmodule

// File: tb/tb_mac_ofifo.sv
// Directed bench for the MAC output FIFO: reset, skewed fill, streaming,
// overflow, wrap-around, full with simultaneous write/pop, and mid-run reset.
module tb_mac_ofifo;
    import mac_pkg::*;

    localparam int W = psum_bw * col;
    localparam int D = depth_default;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mac_ofifo_if bus ();

    mac_ofifo #(.depth(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [W-1:0] row_all(input logic [15:0] v);
        logic [W-1:0] r;
        for (int c = 0; c < col; c++) r[c*psum_bw +: psum_bw] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] row_pat(input int n);
        logic [W-1:0] r;
        for (int c = 0; c < col; c++) r[c*psum_bw +: psum_bw] = 16'(32'h1000 + n*16 + c);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr = '0;
        bus.rd = 1'b0;
        bus.in = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic write_rows(input int first, input int n);
        for (int r = first; r < first + n; r++) begin
            bus.wr = 8'hFF;
            bus.in = row_pat(r);
            step();
        end
        bus.wr = '0;
        bus.in = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #3;
        checks++; if (bus.out !== '0) begin failures++; $display("FAIL rst_out got=%h exp=0", bus.out); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.o_ready); end
        checks++; if (bus.o_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", bus.o_full); end
        checks++; if (bus.o_overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", bus.o_overflow); end
        step();
        reset = 1'b1;
        step();
        bus.rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid cyc=%0d got=%b exp=0", i, bus.o_valid); end
            checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL rst_rd_ready cyc=%0d got=%b exp=0", i, bus.o_ready); end
        end
        idle();
    endtask

    task automatic test_skewed();
        logic [W-1:0] exp_row;
        do_reset();
        for (int c = 0; c < col; c++) begin
            checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL skew_ready_early col=%0d got=%b exp=0", c, bus.o_ready); end
            bus.wr = 8'(1 << c);
            bus.in = '0;
            bus.in[c*psum_bw +: psum_bw] = 16'(256 + c);
            exp_row[c*psum_bw +: psum_bw] = 16'(256 + c);
            step();
        end
        idle();
        checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL skew_ready got=%b exp=1", bus.o_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL skew_valid_pre got=%b exp=0", bus.o_valid); end
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL skew_valid got=%b exp=1", bus.o_valid); end
        checks++; if (bus.out !== exp_row) begin failures++; $display("FAIL skew_row got=%h exp=%h", bus.out, exp_row); end
        step();
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL skew_valid_drop got=%b exp=0", bus.o_valid); end
        checks++; if (bus.out !== exp_row) begin failures++; $display("FAIL skew_hold got=%h exp=%h", bus.out, exp_row); end
        checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL skew_empty got=%b exp=0", bus.o_ready); end
    endtask

    task automatic test_streaming();
        logic exp_v;
        do_reset();
        bus.rd = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) begin
                bus.wr = 8'hFF;
                bus.in = row_all(16'(i));
            end else begin
                bus.wr = '0;
                bus.in = '0;
            end
            step();
            exp_v = (i >= 1) && (i <= 20);
            checks++; if (bus.o_valid !== exp_v) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, bus.o_valid, exp_v); end
            if (exp_v) begin
                checks++; if (bus.out !== row_all(16'(i - 1))) begin failures++; $display("FAIL stream_row cyc=%0d got=%h exp=%h", i, bus.out, row_all(16'(i - 1))); end
            end
        end
        idle();
        checks++; if (bus.o_overflow !== 1'b0) begin failures++; $display("FAIL stream_ovf got=%b exp=0", bus.o_overflow); end
        checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL stream_empty got=%b exp=0", bus.o_ready); end
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int k = 0; k <= D; k++) begin
            if (k == D - 1) begin
                checks++; if (bus.o_full !== 1'b0) begin failures++; $display("FAIL ovf_full_early got=%b exp=0", bus.o_full); end
            end
            if (k == D) begin
                checks++; if (bus.o_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", bus.o_full); end
                checks++; if (bus.o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b exp=0", bus.o_overflow); end
            end
            bus.wr = 8'h01;
            bus.in = '0;
            bus.in[15:0] = 16'(32'h0A00 + k);
            step();
        end
        idle();
        checks++; if (bus.o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", bus.o_overflow); end
        for (int k = 0; k < D; k++) begin
            bus.wr = 8'hFE;
            bus.in = row_all(16'(32'h0B00 + k));
            step();
        end
        idle();
        checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL ovf_ready got=%b exp=1", bus.o_ready); end
        bus.rd = 1'b1;
        for (int k = 0; k < D; k++) begin
            step();
            checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL ovf_drain_valid k=%0d got=%b exp=1", k, bus.o_valid); end
            checks++; if (bus.out[15:0] !== 16'(32'h0A00 + k)) begin failures++; $display("FAIL ovf_col0 k=%0d got=%h exp=%h", k, bus.out[15:0], 16'(32'h0A00 + k)); end
        end
        bus.rd = 1'b0;
        step();
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL ovf_after_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL ovf_after_ready got=%b exp=0", bus.o_ready); end
        checks++; if (bus.o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.o_overflow); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] sb[$];
        logic [W-1:0] exp_row;
        do_reset();
        write_rows(0, D);
        for (int r = 0; r < D; r++) sb.push_back(row_pat(r));
        checks++; if (bus.o_full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%b exp=1", bus.o_full); end
        bus.rd = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            exp_row = sb.pop_front();
            checks++; if (bus.o_valid !== 1'b1 || bus.out !== exp_row) begin failures++; $display("FAIL wrap_drain1 k=%0d valid=%b got=%h exp=%h", k, bus.o_valid, bus.out, exp_row); end
        end
        bus.rd = 1'b0;
        write_rows(D, 10);
        for (int r = D; r < D + 10; r++) sb.push_back(row_pat(r));
        checks++; if (bus.o_full !== 1'b1) begin failures++; $display("FAIL wrap_refull got=%b exp=1", bus.o_full); end
        bus.rd = 1'b1;
        for (int k = 0; k < D; k++) begin
            step();
            exp_row = sb.pop_front();
            checks++; if (bus.o_valid !== 1'b1 || bus.out !== exp_row) begin failures++; $display("FAIL wrap_drain2 k=%0d valid=%b got=%h exp=%h", k, bus.o_valid, bus.out, exp_row); end
        end
        bus.rd = 1'b0;
        step();
        checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b exp=0", bus.o_ready); end
        checks++; if (bus.o_overflow !== 1'b0) begin failures++; $display("FAIL wrap_ovf got=%b exp=0", bus.o_overflow); end
    endtask

    task automatic test_full_simul();
        logic [W-1:0] exp_row;
        do_reset();
        write_rows(0, D);
        checks++; if (bus.o_full !== 1'b1) begin failures++; $display("FAIL simul_full_pre got=%b exp=1", bus.o_full); end
        bus.wr = 8'hFF;
        bus.in = row_all(16'hABCD);
        bus.rd = 1'b1;
        step();
        bus.wr = '0;
        bus.in = '0;
        checks++; if (bus.o_valid !== 1'b1 || bus.out !== row_pat(0)) begin failures++; $display("FAIL simul_first valid=%b got=%h exp=%h", bus.o_valid, bus.out, row_pat(0)); end
        checks++; if (bus.o_overflow !== 1'b0) begin failures++; $display("FAIL simul_ovf got=%b exp=0", bus.o_overflow); end
        checks++; if (bus.o_full !== 1'b1) begin failures++; $display("FAIL simul_full got=%b exp=1", bus.o_full); end
        for (int k = 0; k < D; k++) begin
            step();
            exp_row = (k < D - 1) ? row_pat(k + 1) : row_all(16'hABCD);
            checks++; if (bus.o_valid !== 1'b1 || bus.out !== exp_row) begin failures++; $display("FAIL simul_drain k=%0d valid=%b got=%h exp=%h", k, bus.o_valid, bus.out, exp_row); end
        end
        bus.rd = 1'b0;
        step();
        checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL simul_empty got=%b exp=0", bus.o_ready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_rows(0, 3);
        bus.rd = 1'b1;
        step();
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL mid_valid_pre got=%b exp=1", bus.o_valid); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL mid_valid_async got=%b exp=0", bus.o_valid); end
        checks++; if (bus.out !== '0) begin failures++; $display("FAIL mid_out_async got=%h exp=0", bus.out); end
        checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_async got=%b exp=0", bus.o_ready); end
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL mid_valid_post cyc=%0d got=%b exp=0", i, bus.o_valid); end
        end
        bus.rd = 1'b0;
        bus.wr = 8'h01;
        bus.in = row_all(16'h5555);
        step();
        idle();
        checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL mid_partial_ready got=%b exp=0", bus.o_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_skewed();
        test_streaming();
        test_full_overflow();
        test_wrap();
        test_full_simul();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
